gpr_file: RTL
=============

// Module: gpr_file
// PURPOSE
//  Parametrised general-purpose register file for the nic8 datapath. NREGS
//  registers of WIDTH bits share one tri-state data bus. Each register has an
//  active-low load strobe and an active-low bus-drive strobe. Register IDX is
//  an index register that can also increment or decrement in place, with zero
//  and wrap flags. All loads are synchronous to one clock, not per-register
//  trigger edges.
// PARAMETERS
//  WIDTH  8  bits per register and width of dbus
//  NREGS  4  number of registers; legal range 2..16
//  IDX    2  index of the inc/dec register; must be < NREGS
// PORTS
//  clkBar    in    1            inverted system clock; state updates on falling edge of clkBar
//  resetBar  in    1            asynchronous active-low reset
//  loadBar   in    NREGS        active-low load strobes; bit i selects register i
//  assertBar in    NREGS        active-low bus-drive strobes; bit i selects register i
//  incIdx    in    1            increment register IDX at the next edge
//  decIdx    in    1            decrement register IDX at the next edge
//  dbus      inout WIDTH        shared data bus
//  regs      out   NREGS*WIDTH  register contents; reg i is regs[i*WIDTH +: WIDTH]
//  idxZero   out   1            combinational: register IDX == 0
//  idxWrap   out   1            registered one-cycle wrap pulse
//  busError  out   1            sticky bus-contention flag; see CONFIGURATION
// BEHAVIOUR
//  Reset
//   - resetBar=0 immediately clears every register, idxWrap and busError,
//     regardless of clock.
//   - Reset held or applied mid-cycle overrides any load, inc or dec.
//  Load
//   - At each falling clkBar edge, every register i with loadBar[i]=0 samples dbus.
//   - Several loads in one edge are legal; all loaded registers take the same value.
//  Bus drive
//   - dbus = reg i while assertBar[i]=0; dbus = 'z when no bit is low.
//   - Drive is combinational, with no clock latency.
//   - More than one low assertBar bit is a design error and the bus value is undefined.
//  Transfers
//   - assertBar[j]=0 with loadBar[k]=0 copies reg j to reg k in one edge.
//   - A register may assert and load itself in the same edge; its value is unchanged.
//  Index register (register IDX) priority at each edge
//   - Load beats inc/dec.
//   - incIdx and decIdx together cause no change.
//   - Otherwise the register steps +1 or -1, modulo 2^WIDTH.
//  idxWrap
//   - Goes to 1 for exactly the cycle after an effective inc from all-ones or
//     dec from zero; 0 otherwise.
//   - A load that overrides inc/dec gives idxWrap=0.
//  idxZero
//   - Follows register IDX combinationally, so it is 1 during reset.
//  Latency
//   - regs outputs are valid immediately after the edge.
// CONFIGURATION
//  Macro GPR_FILE_CONTENTION_EN
//   - Defined: at each edge, if two or more assertBar bits are low, busError is
//     set to 1. It stays 1 until resetBar=0.
//   - Undefined: no detector is built and busError is tied to 0.
// TESTING (WIDTH=8, NREGS=4, IDX=2)
//  1. resetBar=0 pulse mid-cycle -> all regs 00, idxZero=1, idxWrap=0,
//     busError=0, dbus=z, with no clock edge needed.
//  2. Drive dbus=5A, loadBar=1110, one edge -> reg0=5A, reg1..3=00.
//  3. assertBar=1110, loadBar=1101, one edge -> dbus=5A, reg1=5A.
//  4. Load reg2=FF, then incIdx one edge -> reg2=00, idxZero=1, idxWrap=1 for one
//     cycle. Then decIdx -> reg2=FF, idxWrap=1. Then inc+dec -> FF unchanged, idxWrap=0.
//  5. dbus=33, loadBar=1011 and incIdx=1 on the same edge -> reg2=33, idxWrap=0.
//  6. assertBar=1100 for one edge -> with GPR_FILE_CONTENTION_EN, busError=1 and
//     stays 1 until reset. Without the macro, busError=0.

Source files
------------

// File: rtl/gpr_file.sv
// ---------------------------------------------------------------------------
// gpr_file : general-purpose register file for the nic8 datapath.
//
// NREGS registers of WIDTH bits share one tri-state data bus. Register IDX
// doubles as an index register that can step up or down in place.
// State changes on the falling edge of clkBar; resetBar clears asynchronously.
//
// Ports
//   clkBar     in     1            inverted system clock (falling edge = update)
//   resetBar   in     1            asynchronous active-low reset
//   loadBar    in     NREGS        active-low load strobes, bit i -> register i
//   assertBar  in     NREGS        active-low bus-drive strobes, bit i -> register i
//   incIdx     in     1            step register IDX up at the next edge
//   decIdx     in     1            step register IDX down at the next edge
//   dbus       inout  WIDTH        shared data bus
//   regs       out    NREGS*WIDTH  register contents, reg i = regs[i*WIDTH +: WIDTH]
//   idxZero    out    1            combinational: register IDX == 0
//   idxWrap    out    1            registered one-cycle wrap pulse
//   busError   out    1            sticky bus-contention flag
//
// Build option
//   GPR_FILE_CONTENTION_EN : when defined, a sticky detector flags any edge at
//   which two or more assertBar bits are low. When undefined, busError is 0.
// ---------------------------------------------------------------------------
module gpr_file #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int IDX   = 2
) (
    input  logic                   clkBar,
    input  logic                   resetBar,
    input  logic [NREGS-1:0]       loadBar,
    input  logic [NREGS-1:0]       assertBar,
    input  logic                   incIdx,
    input  logic                   decIdx,
    inout  wire  [WIDTH-1:0]       dbus,
    output logic [NREGS*WIDTH-1:0] regs,
    output logic                   idxZero,
    output logic                   idxWrap,
    output logic                   busError
);

    logic [NREGS-1:0][WIDTH-1:0] regs_q;
    logic [NREGS-1:0][WIDTH-1:0] regs_d;
    logic                        wrap_q;
    logic                        wrap_d;
    logic [WIDTH-1:0]            bus_val;
    logic                        bus_en;

    // Bus drive: AND-OR mux of every asserted register. With one strobe low
    // this is exactly that register; with several low the value is undefined
    // anyway, and the OR form keeps the mux free of priority logic.
    always_comb begin
        bus_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (!assertBar[i]) begin
                bus_val = bus_val | regs_q[i];
            end
        end
        bus_en = (assertBar != '1);
    end

    assign dbus = bus_en ? bus_val : 'z;

    // Next state. Loads sample whatever is on dbus, which covers both external
    // drivers and register-to-register transfers within the same edge.
    always_comb begin
        regs_d = regs_q;
        wrap_d = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (!loadBar[i]) begin
                regs_d[i] = dbus;
            end
        end
        // A load of the index register wins over stepping; inc and dec together
        // cancel out.
        if (loadBar[IDX] && (incIdx ^ decIdx)) begin
            if (incIdx) begin
                regs_d[IDX] = regs_q[IDX] + WIDTH'(1);
                wrap_d      = (regs_q[IDX] == '1);
            end else begin
                regs_d[IDX] = regs_q[IDX] - WIDTH'(1);
                wrap_d      = (regs_q[IDX] == '0);
            end
        end
    end

    always_ff @(negedge clkBar or negedge resetBar) begin
        if (!resetBar) begin
            regs_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            wrap_q <= wrap_d;
        end
    end

    assign regs    = regs_q;
    assign idxZero = (regs_q[IDX] == '0);
    assign idxWrap = wrap_q;

`ifdef GPR_FILE_CONTENTION_EN
    logic [NREGS-1:0] act;
    logic             multi_drive;
    logic             err_q;
    logic             err_d;

    // x & (x-1) clears the lowest set bit; anything left means two or more
    // registers are driving the bus.
    always_comb begin
        act         = ~assertBar;
        multi_drive = ((act & (act - NREGS'(1))) != '0);
        err_d       = err_q | multi_drive;
    end

    always_ff @(negedge clkBar or negedge resetBar) begin
        if (!resetBar) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign busError = err_q;
`else
    assign busError = 1'b0;
`endif

endmodule
